// File: rtl/face_det_pkg.sv
// Shared constants and types for the face-detection list path.
// Holds entry geometry, verdict codes and the list buffer state encoding.
package face_det_pkg;

  localparam int unsigned FACE_LIST_DEPTH = 16;
  localparam int unsigned FACE_POS_W      = 21;
  localparam int unsigned SIZE_W          = 2;
  localparam int unsigned ENTRY_W         = SIZE_W + FACE_POS_W;
  localparam int unsigned IDX_W           = 4;
  localparam int unsigned CNT_W           = 5;

  localparam logic [1:0] PASS_ACCEPT = 2'b11;
  localparam logic [1:0] PASS_REJECT = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StPend   = 2'd2
  } fl_state_e;

endpackage

// File: rtl/face_list_bank.sv
// One 16-entry bank of face entries: single write port, asynchronous read port.
// Contents are not reset; validity is tracked by the owner's counters.
module face_list_bank
  import face_det_pkg::*;
(
  input  logic               iClk,
  input  logic               iWe,
  input  logic [IDX_W-1:0]   iWaddr,
  input  logic [ENTRY_W-1:0] iWdata,
  input  logic [IDX_W-1:0]   iRaddr,
  output logic [ENTRY_W-1:0] oRdata
);

  logic [ENTRY_W-1:0] mem_q [FACE_LIST_DEPTH];

  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem_q[iWaddr] <= iWdata;
    end
  end

  assign oRdata = mem_q[iRaddr];

endmodule

// File: rtl/face_list_buffer.sv
// Double-buffered face list: captures accepted faces into one bank while the
// other bank, closed at frame end, is streamed out to the overlay drawer.
module face_list_buffer
  import face_det_pkg::*;
(
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic [1:0]            iPass,
  input  logic [SIZE_W-1:0]     iSize,
  input  logic [FACE_POS_W-1:0] iFace_Pos,
  input  logic                  iFrame_Start,
  input  logic                  iFrame_End,
  input  logic                  iRd_Ready,
  output logic                  oRd_Valid,
  output logic [SIZE_W-1:0]     oRd_Size,
  output logic [FACE_POS_W-1:0] oRd_Pos,
  output logic                  oRd_Last,
  output logic [CNT_W-1:0]      oCount,
  output logic                  oOverflow,
  output logic                  oBusy
);

  fl_state_e          state_q, state_d;
  logic               bank_sel_q, bank_sel_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               ovf_q, ovf_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               pend_q, pend_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [ENTRY_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept;
  logic [CNT_W-1:0]   wr_base;
  logic               cap_we;
  logic [CNT_W-1:0]   wr_cnt_cap;
  logic [ENTRY_W-1:0] wr_entry;
  logic [IDX_W-1:0]   rd_nxt;
  logic [IDX_W-1:0]   raddr0, raddr1;
  logic [ENTRY_W-1:0] rdata0, rdata1;
  logic [ENTRY_W-1:0] cap_rdata, disp_rdata, head_entry;
  logic               hs;

  // Frame start clears first, so a same-cycle accept lands at index 0.
  assign accept     = (iPass == PASS_ACCEPT);
  assign wr_base    = iFrame_Start ? '0 : wr_cnt_q;
  assign cap_we     = accept && (wr_base != CNT_W'(FACE_LIST_DEPTH));
  assign wr_cnt_cap = cap_we ? wr_base + CNT_W'(1) : wr_base;
  assign wr_entry   = {iSize, iFace_Pos};
  assign ovf_d      = (ovf_q & ~iFrame_Start) | (accept & ~cap_we);

  assign rd_nxt = rd_idx_q + IDX_W'(1);
  assign hs     = valid_q & iRd_Ready;

  // bank_sel_q names the capture bank; the other one is on display.
  assign raddr0     = bank_sel_q ? rd_nxt : '0;
  assign raddr1     = bank_sel_q ? '0 : rd_nxt;
  assign cap_rdata  = bank_sel_q ? rdata1 : rdata0;
  assign disp_rdata = bank_sel_q ? rdata0 : rdata1;
  // A write to entry 0 on the swap cycle is not in the array yet.
  assign head_entry = (cap_we && (wr_base == '0)) ? wr_entry : cap_rdata;

  face_list_bank u_bank0 (
    .iClk   (iClk),
    .iWe    (cap_we & ~bank_sel_q),
    .iWaddr (wr_base[IDX_W-1:0]),
    .iWdata (wr_entry),
    .iRaddr (raddr0),
    .oRdata (rdata0)
  );

  face_list_bank u_bank1 (
    .iClk   (iClk),
    .iWe    (cap_we & bank_sel_q),
    .iWaddr (wr_base[IDX_W-1:0]),
    .iWdata (wr_entry),
    .iRaddr (raddr1),
    .oRdata (rdata1)
  );

  always_comb begin
    state_d    = state_q;
    bank_sel_d = bank_sel_q;
    wr_cnt_d   = wr_cnt_cap;
    rd_idx_d   = rd_idx_q;
    pend_d     = pend_q;
    valid_d    = valid_q;
    last_d     = last_q;
    data_d     = data_q;
    count_d    = count_q;

    case (state_q)
      StIdle, StPend: begin
        if ((state_q == StPend) || iFrame_End) begin
          bank_sel_d = ~bank_sel_q;
          count_d    = wr_cnt_cap;
          wr_cnt_d   = '0;
          pend_d     = 1'b0;
          rd_idx_d   = '0;
          if (wr_cnt_cap != '0) begin
            state_d = StStream;
            valid_d = 1'b1;
            data_d  = head_entry;
            last_d  = (wr_cnt_cap == CNT_W'(1));
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
          end
        end
      end
      StStream: begin
        if (iFrame_End) begin
          pend_d = 1'b1;
        end
        if (hs) begin
          if (last_q) begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            data_d   = '0;
            rd_idx_d = '0;
            state_d  = pend_d ? StPend : StIdle;
          end else begin
            rd_idx_d = rd_nxt;
            data_d   = disp_rdata;
            last_d   = ({1'b0, rd_nxt} == (count_q - CNT_W'(1)));
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q    <= StIdle;
      bank_sel_q <= 1'b0;
      wr_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      rd_idx_q   <= '0;
      pend_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      bank_sel_q <= bank_sel_d;
      wr_cnt_q   <= wr_cnt_d;
      ovf_q      <= ovf_d;
      rd_idx_q   <= rd_idx_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      count_q    <= count_d;
    end
  end

  assign oRd_Valid = valid_q;
  assign oRd_Last  = last_q;
  assign oRd_Size  = data_q[ENTRY_W-1 -: SIZE_W];
  assign oRd_Pos   = data_q[FACE_POS_W-1:0];
  assign oCount    = count_q;
  assign oOverflow = ovf_q;
  assign oBusy     = (state_q != StIdle) | pend_q;

endmodule
